// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receive engine.
// Synchronises the raw rxd pin, checks the start bit at its middle, samples
// DATA_BITS data bits LSB first at 16-tick spacing, checks the stop bit, and
// presents each word with frame/parity error flags and a one-cycle rx_valid.
// Optional feature macro: UART_RX_PARITY_EN adds a parity bit after the data
// bits (sense chosen by PARITY_ODD). Without it, frames are start+data+stop
// and parity_error is held at 0.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx_enable,
  input  logic                 rx_tick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_error,
  output logic                 parity_error,
  output logic                 busy
);

  localparam int BCW = $clog2(DATA_BITS);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state;
  logic                 sync1;
  logic                 sync2;
  logic                 rxs;
  logic                 armed;
  logic [3:0]           os_cnt;
  logic [BCW-1:0]       bit_cnt;
  logic [DATA_BITS-1:0] shreg;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bad;
  logic                 parity_flag;
`endif

  assign rxs = sync2;

  // Two-flop synchroniser on the asynchronous pin; idles high so reset to 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rxd;
      sync2 <= sync1;
    end
  end

  // Receive FSM with all counters, the break lock-out and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      armed        <= 1'b1;
      os_cnt       <= 4'd0;
      bit_cnt      <= '0;
      shreg        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      frame_error  <= 1'b0;
      busy         <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad   <= 1'b0;
      parity_flag  <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
      if (!rx_enable) begin
        state   <= IDLE;
        os_cnt  <= 4'd0;
        bit_cnt <= '0;
        busy    <= 1'b0;
      end else if (rx_tick) begin
        if (rxs) begin
          armed <= 1'b1;
        end
        case (state)
          IDLE: begin
            os_cnt  <= 4'd0;
            bit_cnt <= '0;
            if (!rxs && armed) begin
              state <= START;
              busy  <= 1'b1;
            end
          end
          START: begin
            if (os_cnt == 4'd7) begin
              os_cnt  <= 4'd0;
              bit_cnt <= '0;
              if (!rxs) begin
                state <= DATA;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
          DATA: begin
            os_cnt <= os_cnt + 4'd1;
            if (os_cnt == 4'd15) begin
              shreg <= {rxs, shreg[DATA_BITS-1:1]};
              if (bit_cnt == LAST_BIT) begin
                bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                state   <= PARITY;
`else
                state   <= STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            os_cnt <= os_cnt + 4'd1;
            if (os_cnt == 4'd15) begin
              parity_bad <= (^shreg) ^ rxs ^ PARITY_ODD;
              state      <= STOP;
            end
          end
`endif
          STOP: begin
            os_cnt <= os_cnt + 4'd1;
            if (os_cnt == 4'd15) begin
              rx_data     <= shreg;
              frame_error <= !rxs;
`ifdef UART_RX_PARITY_EN
              parity_flag <= parity_bad;
`endif
              rx_valid    <= 1'b1;
              busy        <= 1'b0;
              state       <= IDLE;
              if (!rxs) begin
                armed <= 1'b0;
              end
            end
          end
          default: begin
            state  <= IDLE;
            os_cnt <= 4'd0;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  assign parity_error = parity_flag;
`else
  // Parity sense is meaningless without a parity bit; the AND keeps the
  // parameter referenced while forcing the flag low.
  assign parity_error = 1'b0 & PARITY_ODD;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames checked against a frame-level
// model (queue of expected words). Honors UART_RX_PARITY_EN when defined.
module tb_uart_rx;

  localparam int DATA_BITS  = 8;
  localparam bit PARITY_ODD = 1'b0;
  localparam int BIT_CLKS   = 64;

  typedef struct {
    logic [7:0] data;
    logic       fe;
    logic       pe;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic       rx_enable;
  logic       rx_tick;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;
  logic       parity_error;
  logic       busy;

  exp_t       exp_q[$];
  logic [7:0] last_data;
  int         checks;
  int         errors;

  uart_rx #(
    .DATA_BITS (DATA_BITS),
    .PARITY_ODD(PARITY_ODD)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx_enable   (rx_enable),
    .rx_tick     (rx_tick),
    .rxd         (rxd),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_error (frame_error),
    .parity_error(parity_error),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Oversample strobe: one clk high out of every four.
  initial begin
    rx_tick = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 rx_tick = 1'b1;
      @(posedge clk);
      #1 rx_tick = 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Every rx_valid pulse must match the oldest outstanding expected frame.
  always @(negedge clk) begin
    if (reset_n && rx_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("rx_data", {24'd0, rx_data}, {24'd0, e.data});
        checkOutput("frame_error", {31'd0, frame_error}, {31'd0, e.fe});
        checkOutput("parity_error", {31'd0, parity_error}, {31'd0, e.pe});
        last_data = e.data;
      end
    end
  end

  // Hold rxd at b for one bit time; optionally check busy a third of the way in.
  task automatic sendBit(input logic b, input bit chk_busy);
    rxd = b;
    if (chk_busy) begin
      repeat (24) @(posedge clk);
      @(negedge clk);
      checkOutput("busy_in_frame", {31'd0, busy}, 32'd1);
      repeat (BIT_CLKS - 24) @(posedge clk);
    end else begin
      repeat (BIT_CLKS) @(posedge clk);
    end
    #1;
  endtask

  task automatic idleBits(input int n);
    rxd = 1'b1;
    repeat (n * BIT_CLKS) @(posedge clk);
    #1;
  endtask

  // Send one full frame and queue the word the receiver should report.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                               input logic par_flip, input bit chk_busy);
    exp_t e;
    e.data = data;
    e.fe   = !stop_bit;
`ifdef UART_RX_PARITY_EN
    e.pe   = par_flip;
`else
    e.pe   = 1'b0;
`endif
    exp_q.push_back(e);
    sendBit(1'b0, chk_busy);
    for (int i = 0; i < DATA_BITS; i++) sendBit(data[i], chk_busy);
`ifdef UART_RX_PARITY_EN
    sendBit((^data) ^ PARITY_ODD ^ par_flip, chk_busy);
`endif
    sendBit(stop_bit, chk_busy);
  endtask

  initial begin
    logic [7:0] d;
    checks    = 0;
    errors    = 0;
    last_data = 8'h00;
    reset_n   = 1'b0;
    rx_enable = 1'b1;
    rxd       = 1'b1;
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_rx_data", {24'd0, rx_data}, 32'd0);
    checkOutput("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("reset_frame_error", {31'd0, frame_error}, 32'd0);
    checkOutput("reset_parity_error", {31'd0, parity_error}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    idleBits(1);

    $display("[TB] single frame 0xA5");
    applyStimulus(8'hA5, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("busy_after_frame", {31'd0, busy}, 32'd0);
    checkOutput("pending_a5", exp_q.size(), 32'd0);
    @(posedge clk); #1;
    idleBits(1);

    $display("[TB] back-to-back 0x00 0xFF");
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'hFF, 1'b1, 1'b0, 1'b0);
    idleBits(1);
    checkOutput("pending_b2b", exp_q.size(), 32'd0);

    $display("[TB] start glitch");
    rxd = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    checkOutput("glitch_busy_rise", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    rxd = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    checkOutput("glitch_busy_fall", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    idleBits(1);
    checkOutput("glitch_no_valid", exp_q.size(), 32'd0);

    $display("[TB] break after bad stop");
    applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0);
    rxd = 1'b0;
    repeat (30 * BIT_CLKS) @(posedge clk);
    #1;
    idleBits(2);
    checkOutput("break_single_frame", exp_q.size(), 32'd0);
    applyStimulus(8'h12, 1'b1, 1'b0, 1'b0);
    idleBits(1);
    checkOutput("pending_after_break", exp_q.size(), 32'd0);

`ifdef UART_RX_PARITY_EN
    $display("[TB] parity");
    applyStimulus(8'h07, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h07, 1'b1, 1'b1, 1'b0);
    idleBits(1);
    checkOutput("pending_parity", exp_q.size(), 32'd0);
`endif

    $display("[TB] disable mid-frame");
    d = 8'h6B;
    sendBit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) sendBit(d[i], 1'b0);
    rxd = d[4];
    repeat (32) @(posedge clk);
    @(negedge clk);
    checkOutput("busy_before_disable", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    rx_enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("busy_after_disable", {31'd0, busy}, 32'd0);
    checkOutput("data_kept_disable", {24'd0, rx_data}, {24'd0, last_data});
    @(posedge clk); #1;
    for (int i = 5; i < DATA_BITS; i++) sendBit(d[i], 1'b0);
    sendBit(1'b1, 1'b0);
    idleBits(2);
    rx_enable = 1'b1;
    idleBits(1);
    checkOutput("disable_no_valid", exp_q.size(), 32'd0);
    checkOutput("data_kept_reenable", {24'd0, rx_data}, {24'd0, last_data});

    $display("[TB] random frames");
    for (int n = 0; n < 30; n++) begin
      logic stop_ok;
      int   gap;
      d       = 8'($urandom);
      stop_ok = ($urandom_range(0, 9) != 0);
      gap     = $urandom_range(0, 2);
      if (!stop_ok && gap == 0) gap = 1;
      applyStimulus(d, stop_ok, 1'($urandom_range(0, 1)), 1'b0);
      if (gap > 0) idleBits(gap);
    end
    idleBits(1);
    checkOutput("pending_random", exp_q.size(), 32'd0);

    $display("[TB] reset mid-frame");
    sendBit(1'b0, 1'b0);
    sendBit(1'b1, 1'b0);
    sendBit(1'b0, 1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
    checkOutput("midreset_rx_data", {24'd0, rx_data}, 32'd0);
    checkOutput("midreset_frame_error", {31'd0, frame_error}, 32'd0);
    last_data = 8'h00;
    rxd = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b1;
    idleBits(1);
    checkOutput("midreset_no_valid", exp_q.size(), 32'd0);
    applyStimulus(8'hC3, 1'b1, 1'b0, 1'b0);
    idleBits(1);
    checkOutput("pending_final", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receive engine that deserialises an asynchronous serial line into parallel data words. It consumes the 16x oversampling `rx_tick` strobe from the baud rate generator, synchronises the raw `rxd` pin, validates start and stop bits, and presents each received word with per-frame error flags. It sits between the pad and the APB register/FIFO layer, on the receive path alongside the baud rate generator.

## Interface
- `DATA_BITS`, 8, data bits per frame, legal range 5..9, sent LSB first.
- `PARITY_ODD`, 0, selects parity sense: 0 = even, 1 = odd. Used only when `UART_RX_PARITY_EN` is defined.
- `clk`  input  1  system clock; the block has one clock.
- `reset_n`  input  1  asynchronous, active-low reset.
- `rx_enable`  input  1  receiver enable; also drives the baud rate generator's `rx_enable`.
- `rx_tick`  input  1  single-cycle strobe at 16x the baud rate.
- `rxd`  input  1  raw serial line; idles high.
- `rx_data`  output  DATA_BITS  last received word.
- `rx_valid`  output  1  one-cycle pulse when a frame completes.
- `frame_error`  output  1  stop bit sampled low in the last frame.
- `parity_error`  output  1  parity mismatch in the last frame.
- `busy`  output  1  high whenever the FSM is outside IDLE.

## Operation
- `rxd` passes through a 2-flop synchroniser. Both flops reset to 1.
- A 4-bit oversample counter `os_cnt` advances only on `rx_tick`. A bit counter counts 0..DATA_BITS-1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on a tick with synced rxd=0 and `armed`=1, go to START and clear `os_cnt`.
  - START: on the tick where `os_cnt`=7, which is mid start bit:
    - if rxd=0, go to DATA with `os_cnt` cleared;
    - if rxd=1, treat it as a glitch and return to IDLE with no outputs changed.
  - DATA: on each tick where `os_cnt`=15, shift rxd into the MSB of the shift register (right shift, so the result is LSB first) and increment the bit counter.
    - After bit DATA_BITS-1, go to PARITY if `UART_RX_PARITY_EN` is defined, otherwise go to STOP.
  - PARITY: on the tick where `os_cnt`=15, sample the parity bit and go to STOP.
  - STOP: on the tick where `os_cnt`=15, sample the stop bit, then:
    - load `rx_data` from the shift register;
    - load `frame_error` = !stop and `parity_error`;
    - pulse `rx_valid`;
    - return to IDLE.
- `rx_valid` is asserted for every completed frame, including errored ones. The error flags qualify that word.
- `rx_data`, `frame_error` and `parity_error` hold their values until the next frame completes.
- `armed` is cleared when a frame ends with a frame error, and set on any tick with synced rxd=1. A held break therefore produces exactly one errored frame, not a stream of them.
- When `rx_enable`=0, the FSM is forced to IDLE, `os_cnt` and the bit counter clear, and ticks are ignored. Deasserting `rx_enable` mid-frame aborts the frame with no `rx_valid`. Registered outputs keep their values.

## Timing
- Reset values:
  - `rx_data`=0, `rx_valid`=0, `frame_error`=0, `parity_error`=0, `busy`=0;
  - FSM=IDLE, `armed`=1, counters=0.
- Input latency: 2 clk from a `rxd` edge to the synced value.
- Start detection resolves to within 1 tick. Each data bit is sampled 16 ticks after the previous sample, which places samples near mid-bit.
- Output latency: `rx_valid`, `rx_data` and the error flags update on the clk edge after the `rx_tick` cycle in which the stop bit is sampled. `rx_valid` is high for exactly 1 clk.
- `busy` rises 1 clk after the start-detect tick and falls in the same cycle that `rx_valid` rises.
- A new start bit can be detected on the first tick after returning to IDLE (given `armed`=1). Back-to-back frames with no idle gap are supported.
- Asserting `reset_n` mid-frame returns everything to reset values immediately, with no `rx_valid`.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - a PARITY state follows DATA;
  - the expected parity is the XOR of the data bits, inverted when `PARITY_ODD`=1;
  - `parity_error` is set on mismatch.
- Not defined:
  - the PARITY state and parity logic are absent;
  - the frame is start + DATA_BITS + stop;
  - `parity_error` is tied to 0.

## Test plan
Bench conditions for all scenarios: `rx_tick` every 4 clk, so one bit lasts 64 clk; DATA_BITS=8; `rx_enable`=1 unless stated.

- Send 0xA5 as 8N1 -> one `rx_valid` pulse, `rx_data`=0xA5, both errors 0, `busy` high for the whole frame.
- Send 0x00 then 0xFF back-to-back with no idle gap -> two `rx_valid` pulses, values 0x00 and 0xFF in that order.
- Drive a 2-tick low glitch on an idle line -> no `rx_valid`; `busy` returns to 0 within 8 ticks.
- Send 0x3C with the stop bit low, then hold the line low for 3 frame times -> exactly one `rx_valid` with `frame_error`=1 and `rx_data`=0x3C; then send 0x12 -> `rx_valid`, `frame_error`=0.
- With `UART_RX_PARITY_EN` and `PARITY_ODD`=0: send 0x07 with parity bit 1 -> `parity_error`=0; send 0x07 with parity bit 0 -> `parity_error`=1.
- Deassert `rx_enable` mid-way through bit 4 of a frame -> no `rx_valid`, `busy`=0 on the next clk, `rx_data` unchanged.
